// File: rtl/font_rom_arbiter_if.sv
// font_rom_arbiter_if: display, host and font ROM signal bundle for the arbiter.
// slave = arbiter side, master = renderer/host/ROM side; clk/rst_n stay plain ports.
interface font_rom_arbiter_if #(
    parameter int CHAR_W = 8,
    parameter int ROW_W  = 4
);
    localparam int ADDR_W = CHAR_W + ROW_W;

    logic              disp_req;
    logic [CHAR_W-1:0] disp_char;
    logic [ROW_W-1:0]  disp_row;
    logic              disp_gnt;
    logic              disp_valid;
    logic [7:0]        disp_data;

    logic              host_req;
    logic [ADDR_W-1:0] host_addr;
    logic              host_gnt;
    logic              host_valid;
    logic [7:0]        host_data;

    logic [ADDR_W-1:0] rom_addr;
    logic [7:0]        rom_dout;

    modport slave (
        input  disp_req, disp_char, disp_row,
        output disp_gnt, disp_valid, disp_data,
        input  host_req, host_addr,
        output host_gnt, host_valid, host_data,
        output rom_addr,
        input  rom_dout
    );

    modport master (
        output disp_req, disp_char, disp_row,
        input  disp_gnt, disp_valid, disp_data,
        output host_req, host_addr,
        input  host_gnt, host_valid, host_data,
        input  rom_addr,
        output rom_dout
    );
endinterface

// File: rtl/font_rom_arbiter.sv
// font_rom_arbiter: shares a 1-cycle synchronous font ROM between renderer and host.
// Ports: clk, rst_n (async low), bus (font_rom_arbiter_if.slave): disp_*, host_*, rom_*.
// Optional starvation guard for the host: define FONT_ARB_STARVE_GUARD_EN.
module font_rom_arbiter #(
    parameter int CHAR_W       = 8,
    parameter int ROW_W        = 4,
    parameter int STARVE_LIMIT = 8
) (
    input logic clk,
    input logic rst_n,
    font_rom_arbiter_if.slave bus
);
    localparam int ADDR_W = CHAR_W + ROW_W;

    typedef enum logic [1:0] {
        TAG_NONE = 2'd0,
        TAG_DISP = 2'd1,
        TAG_HOST = 2'd2
    } tag_e;

    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    tag_e              tag1_q, tag1_d;
    tag_e              tag2_q;
    logic [7:0]        disp_hold_q;
    logic [7:0]        host_hold_q;
    logic              force_host;
    logic              disp_gnt;
    logic              host_gnt;

`ifdef FONT_ARB_STARVE_GUARD_EN
    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

    logic [STARVE_W-1:0] starve_q, starve_d;

    assign force_host = bus.host_req &&
                        (starve_q == STARVE_W'(STARVE_LIMIT));

    // Counts only cycles where the host is actually waiting.
    always_comb begin
        starve_d = '0;
        if (bus.host_req && !host_gnt)
            starve_d = starve_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            starve_q <= '0;
        else
            starve_q <= starve_d;
    end
`else
    assign force_host = 1'b0;
`endif

    assign disp_gnt = bus.disp_req && !force_host;
    assign host_gnt = bus.host_req && (!bus.disp_req || force_host);

    always_comb begin
        rom_addr_d = rom_addr_q;
        tag1_d     = TAG_NONE;
        unique case (1'b1)
            disp_gnt: begin
                rom_addr_d = {bus.disp_char, bus.disp_row};
                tag1_d     = TAG_DISP;
            end
            host_gnt: begin
                rom_addr_d = bus.host_addr;
                tag1_d     = TAG_HOST;
            end
            default: ;
        endcase
    end

    // tag2_q lines up with rom_dout: ROM samples rom_addr_q one cycle after tag1_q.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rom_addr_q  <= '0;
            tag1_q      <= TAG_NONE;
            tag2_q      <= TAG_NONE;
            disp_hold_q <= '0;
            host_hold_q <= '0;
        end else begin
            rom_addr_q <= rom_addr_d;
            tag1_q     <= tag1_d;
            tag2_q     <= tag1_q;
            if (tag2_q == TAG_DISP)
                disp_hold_q <= bus.rom_dout;
            if (tag2_q == TAG_HOST)
                host_hold_q <= bus.rom_dout;
        end
    end

    assign bus.disp_gnt   = disp_gnt;
    assign bus.host_gnt   = host_gnt;
    assign bus.rom_addr   = rom_addr_q;
    assign bus.disp_valid = (tag2_q == TAG_DISP);
    assign bus.host_valid = (tag2_q == TAG_HOST);
    assign bus.disp_data  = (tag2_q == TAG_DISP) ? bus.rom_dout : disp_hold_q;
    assign bus.host_data  = (tag2_q == TAG_HOST) ? bus.rom_dout : host_hold_q;
endmodule

// File: tb/tb_font_rom_arbiter.sv
// tb_font_rom_arbiter: directed checks of font_rom_arbiter against a model ROM.
// ROM content: mem[a] = a[7:0] ^ {4'h0, a[11:8]}; define FONT_ARB_STARVE_GUARD_EN to test the guard.
module tb_font_rom_arbiter;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    font_rom_arbiter_if #(.CHAR_W(8), .ROW_W(4)) bus ();

    font_rom_arbiter #(
        .CHAR_W(8),
        .ROW_W(4),
        .STARVE_LIMIT(8)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        bus.rom_dout <= bus.rom_addr[7:0] ^ {4'h0, bus.rom_addr[11:8]};

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        bit guard;
`ifdef FONT_ARB_STARVE_GUARD_EN
        guard = 1'b1;
`else
        guard = 1'b0;
`endif
        rst_n         = 1'b0;
        bus.disp_req  = 1'b0;
        bus.disp_char = '0;
        bus.disp_row  = '0;
        bus.host_req  = 1'b0;
        bus.host_addr = '0;
        bus.rom_dout  = '0;

        // reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_rom_addr", 32'(bus.rom_addr), 32'h000);
        chk("rst_disp_valid", 32'(bus.disp_valid), 0);
        chk("rst_host_valid", 32'(bus.host_valid), 0);
        chk("rst_disp_data", 32'(bus.disp_data), 0);
        chk("rst_host_data", 32'(bus.host_data), 0);
        chk("rst_gnt_idle", 32'({bus.disp_gnt, bus.host_gnt}), 0);
        bus.disp_req = 1'b1;
        #1;
        chk("rst_gnt_comb", 32'(bus.disp_gnt), 1);
        bus.disp_req = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;

        // 1: single display read
        @(posedge clk); #1;
        bus.disp_req  = 1'b1;
        bus.disp_char = 8'h41;
        bus.disp_row  = 4'h3;
        @(negedge clk);
        chk("t1_disp_gnt", 32'(bus.disp_gnt), 1);
        chk("t1_host_gnt", 32'(bus.host_gnt), 0);
        @(posedge clk); #1;
        bus.disp_req = 1'b0;
        @(negedge clk);
        chk("t1_rom_addr", 32'(bus.rom_addr), 32'h413);
        chk("t1_valid_n1", 32'(bus.disp_valid), 0);
        @(negedge clk);
        chk("t1_disp_valid", 32'(bus.disp_valid), 1);
        chk("t1_disp_data", 32'(bus.disp_data), 32'h17);
        chk("t1_host_valid", 32'(bus.host_valid), 0);
        @(negedge clk);
        chk("t1_valid_drop", 32'(bus.disp_valid), 0);
        chk("t1_data_hold", 32'(bus.disp_data), 32'h17);
        chk("t1_addr_hold", 32'(bus.rom_addr), 32'h413);

        // 2: single host read
        @(posedge clk); #1;
        bus.host_req  = 1'b1;
        bus.host_addr = 12'hFFF;
        @(negedge clk);
        chk("t2_host_gnt", 32'(bus.host_gnt), 1);
        chk("t2_disp_gnt", 32'(bus.disp_gnt), 0);
        @(posedge clk); #1;
        bus.host_req = 1'b0;
        @(negedge clk);
        chk("t2_rom_addr", 32'(bus.rom_addr), 32'hFFF);
        chk("t2_valid_n1", 32'(bus.host_valid), 0);
        @(negedge clk);
        chk("t2_host_valid", 32'(bus.host_valid), 1);
        chk("t2_host_data", 32'(bus.host_data), 32'hF0);
        chk("t2_disp_valid", 32'(bus.disp_valid), 0);
        @(negedge clk);
        chk("t2_one_pulse", 32'(bus.host_valid), 0);
        chk("t2_data_hold", 32'(bus.host_data), 32'hF0);

        // 3: alternating display / host / display
        @(posedge clk); #1;
        bus.disp_req  = 1'b1;
        bus.disp_char = 8'h12;
        bus.disp_row  = 4'h5;
        @(negedge clk);
        chk("t3_gnt_a", 32'({bus.disp_gnt, bus.host_gnt}), 32'b10);
        @(posedge clk); #1;
        bus.disp_req  = 1'b0;
        bus.host_req  = 1'b1;
        bus.host_addr = 12'h3A7;
        @(negedge clk);
        chk("t3_gnt_b", 32'({bus.disp_gnt, bus.host_gnt}), 32'b01);
        @(posedge clk); #1;
        bus.host_req  = 1'b0;
        bus.disp_req  = 1'b1;
        bus.disp_char = 8'h7E;
        bus.disp_row  = 4'hF;
        @(negedge clk);
        chk("t3_gnt_c", 32'({bus.disp_gnt, bus.host_gnt}), 32'b10);
        chk("t3_ret_a_v", 32'({bus.disp_valid, bus.host_valid}), 32'b10);
        chk("t3_ret_a_d", 32'(bus.disp_data), 32'h24);
        @(posedge clk); #1;
        bus.disp_req = 1'b0;
        @(negedge clk);
        chk("t3_ret_b_v", 32'({bus.disp_valid, bus.host_valid}), 32'b01);
        chk("t3_ret_b_d", 32'(bus.host_data), 32'hA4);
        @(negedge clk);
        chk("t3_ret_c_v", 32'({bus.disp_valid, bus.host_valid}), 32'b10);
        chk("t3_ret_c_d", 32'(bus.disp_data), 32'hE8);
        @(negedge clk);
        chk("t3_idle_v", 32'({bus.disp_valid, bus.host_valid}), 0);

        // 4: continuous display traffic with a waiting host
        @(posedge clk); #1;
        bus.disp_req  = 1'b1;
        bus.disp_char = 8'h20;
        bus.disp_row  = 4'h0;
        bus.host_req  = 1'b1;
        bus.host_addr = 12'h100;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            chk($sformatf("t4_host_gnt_%0d", k), 32'(bus.host_gnt),
                32'(guard && k == 9));
            chk($sformatf("t4_disp_gnt_%0d", k), 32'(bus.disp_gnt),
                32'(!(guard && k == 9)));
            if (k == 11) begin
                chk("t4_host_valid", 32'(bus.host_valid), 32'(guard));
                if (guard)
                    chk("t4_host_data", 32'(bus.host_data), 32'h01);
            end
            @(posedge clk); #1;
        end
        bus.disp_req = 1'b0;
        bus.host_req = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // 5: reset one cycle after a display grant
        bus.disp_req  = 1'b1;
        bus.disp_char = 8'h55;
        bus.disp_row  = 4'h1;
        @(negedge clk);
        chk("t5_disp_gnt", 32'(bus.disp_gnt), 1);
        @(posedge clk); #1;
        bus.disp_req = 1'b0;
        rst_n        = 1'b0;
        @(negedge clk);
        chk("t5_rom_addr", 32'(bus.rom_addr), 0);
        chk("t5_disp_valid", 32'(bus.disp_valid), 0);
        chk("t5_disp_data", 32'(bus.disp_data), 0);
        chk("t5_host_data", 32'(bus.host_data), 0);
        chk("t5_host_valid", 32'(bus.host_valid), 0);
        chk("t5_gnts", 32'({bus.disp_gnt, bus.host_gnt}), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("t5_no_valid_%0d", k),
                32'({bus.disp_valid, bus.host_valid}), 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
